gate_tt_sequencer: RTL
======================

Name: gate_tt_sequencer

Overview:
- Self-checking stimulus/response stage for any 2-input logic gate in the logic_gate library.
- Drives the gate's in_a/in_b through all four input vectors, holds each for a programmable number of cycles, and samples the gate's out.
- Compares each sample against a parameterised truth table and reports an error count, the first failing vector, and pass/done status.
- Replaces hand-written delay-based stimulus with a clocked, reusable block for bench and on-chip self-test.

Parameters:
- TRUTH_TABLE, 4'b0001: expected out, indexed by idx = {in_b, in_a}. Default is NOR; AND = 4'b1000, XOR = 4'b0110.
- HOLD_CYCLES, 10: cycles each vector is held; legal range 1..65535.
- ERR_W, 8: width of err_cnt.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- loop_en  input  1  at end of vector 3, wrap to vector 0 instead of finishing
- gate_out  input  1  out of the gate under test (combinational)
- in_a  output  1  drives gate in_a
- in_b  output  1  drives gate in_b
- busy  output  1  run in progress
- done  output  1  run finished; held until next accepted start
- pass  output  1  done and zero errors
- err_cnt  output  ERR_W  mismatch count, saturating
- fail_seen  output  1  at least one mismatch this run
- first_fail_idx  output  2  {in_b,in_a} of first mismatch

Behaviour:
- All outputs are registered. Reset asserts asynchronously, deasserts synchronously to clk.
- Reset values: all outputs 0; state IDLE; idx 0; hold counter 0.
- Vector order: idx 0,1,2,3, which drives (a,b) = (0,0), (1,0), (0,1), (1,1). in_a = idx[0], in_b = idx[1].
- States: IDLE, RUN, DONE.
- IDLE/DONE:
  - start=1 at an edge accepts the run.
  - Next cycle: state RUN, busy=1, done=0, pass=0, idx=0, hold=0, err_cnt=0, fail_seen=0, first_fail_idx=0.
  - start=0: stay; outputs hold.
- RUN:
  - hold increments every cycle.
  - At the edge where hold==HOLD_CYCLES-1, gate_out is compared with TRUTH_TABLE[idx].
  - On mismatch:
    - err_cnt increments, saturating at 2^ERR_W-1.
    - If fail_seen==0: first_fail_idx=idx and fail_seen=1.
  - Same edge, advance:
    - If idx<3: idx+1, hold=0.
    - If idx==3 and loop_en=1: idx=0, hold=0, counters retained and accumulate.
    - If idx==3 and loop_en=0: state DONE, busy=0, done=1, pass=(final err_cnt==0). The final compare is included.
  - start is ignored while in RUN.
- Latency: a non-looping run ends exactly 4*HOLD_CYCLES edges after the accept edge. done rises on that edge.
- With HOLD_CYCLES=1, sampling is in the same cycle the vector is driven; a combinational gate_out settles within that cycle.
- loop_en is sampled only at the idx==3 compare edge. Deasserting it mid-round finishes at the end of that round.
- Reset mid-run: immediate return to reset values. No done pulse, no partial pass.
- Overflow: err_cnt saturates and never wraps. fail_seen and first_fail_idx are unaffected by saturation.

Test Plan:
1. Defaults, NOR gate connected, pulse start → in_a/in_b step (0,0),(1,0),(0,1),(1,1) every 10 cycles. done=1 and busy=0 exactly 40 edges after accept. err_cnt=0, pass=1, fail_seen=0.
2. Defaults, gate_out tied 0 → err_cnt=1, fail_seen=1, first_fail_idx=0, pass=0, done=1 at edge 40.
3. TRUTH_TABLE=4'b0110 (XOR expected), NOR connected → mismatches at idx 0,1,2. err_cnt=3, first_fail_idx=0, pass=0.
4. HOLD_CYCLES=2, ERR_W=2, gate_out tied 1, loop_en=1 for 3 rounds then 0 → err_cnt saturates at 3. done only after the round in which loop_en was low at the idx==3 edge. pass=0.
5. start pulsed again at cycle 15 of a run → ignored, run still ends at edge 40. rst_n low at cycle 25 → all outputs 0 immediately. A new start after release runs a clean 40-cycle pass.
6. HOLD_CYCLES=1 → vectors change every cycle. done at edge 4 after accept. pass=1 with NOR connected.

Source files
------------

// File: rtl/gate_tt_if.sv
// Bundle between the truth-table sequencer and whoever controls it.
// slave: the sequencer itself; master: the controller/bench side.
interface gate_tt_if #(
  parameter int ERR_W = 8
);
  // start is a level sampled at rising edges while the sequencer is idle or done;
  // a high sample is the accept, and start is ignored while busy is high.
  logic             start;
  logic             loop_en;
  logic             gate_out;
  logic             in_a;
  logic             in_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_seen;
  logic [1:0]       first_fail_idx;
  logic [1:0]       state_dbg;

  modport slave (
    input  start, loop_en, gate_out,
    output in_a, in_b, busy, done, pass, err_cnt, fail_seen, first_fail_idx, state_dbg
  );

  modport master (
    output start, loop_en, gate_out,
    input  in_a, in_b, busy, done, pass, err_cnt, fail_seen, first_fail_idx, state_dbg
  );
endinterface

// File: rtl/gate_tt_sequencer.sv
// Walks a 2-input gate through its four input vectors, holds each for HOLD_CYCLES,
// and scores the sampled gate output against TRUTH_TABLE.
module gate_tt_sequencer #(
  parameter logic [3:0] TRUTH_TABLE = 4'b0001,
  parameter int         HOLD_CYCLES = 10,
  parameter int         ERR_W       = 8
) (
  input logic       clk,
  input logic       rst_n,
  gate_tt_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [15:0]      HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t           state;
  logic [1:0]       idx;
  logic [15:0]      hold;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_seen;
  logic [1:0]       first_fail_idx;

  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  // Score of the current vector, only committed on the last hold cycle.
  always_comb begin
    mismatch = 1'b0;
    err_next = err_cnt;
    mismatch = (bus.gate_out != TRUTH_TABLE[idx]);
    if (mismatch && (err_cnt != ERR_MAX)) begin
      err_next = err_cnt + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= 2'd0;
      hold           <= 16'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      fail_seen      <= 1'b0;
      first_fail_idx <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state          <= RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            idx            <= 2'd0;
            hold           <= 16'd0;
            err_cnt        <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= 2'd0;
          end
        end
        RUN: begin
          if (hold == HOLD_LAST) begin
            err_cnt <= err_next;
            if (mismatch && !fail_seen) begin
              fail_seen      <= 1'b1;
              first_fail_idx <= idx;
            end
            hold <= 16'd0;
            if (idx != 2'd3) begin
              idx <= idx + 2'd1;
            end else if (bus.loop_en) begin
              idx <= 2'd0;
            end else begin
              // Final vector's compare is folded into pass on this same edge.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end
          end else begin
            hold <= hold + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_a           = idx[0];
  assign bus.in_b           = idx[1];
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.pass           = pass;
  assign bus.err_cnt        = err_cnt;
  assign bus.fail_seen      = fail_seen;
  assign bus.first_fail_idx = first_fail_idx;
  assign bus.state_dbg      = state;

endmodule
